// File: rtl/tone_if.sv
// Sequencer-to-tone-generator link.
//   note_code : {octave[6:4], note[3:0]} driven by the sequencer
//   volume    : 4-bit PWM level, 0 = mute
//   sq_out    : raw square wave from the generator
//   audio_out : PWM-gated square wave for the speaker pin
//   active    : high while a pitched note is being played
interface tone_if;
  logic [6:0] note_code;
  logic [3:0] volume;
  logic       sq_out;
  logic       audio_out;
  logic       active;

  modport master (
    output note_code,
    output volume,
    input  sq_out,
    input  audio_out,
    input  active
  );

  modport slave (
    input  note_code,
    input  volume,
    output sq_out,
    output audio_out,
    output active
  );
endinterface

// File: rtl/tone_generator.sv
// Square-wave tone generator with PWM volume gate.
// Divides clk by a per-note half-period (C..B table for octave 0) shifted
// right by the octave field. Pitch changes are deferred to the next toggle
// so a half-cycle is never cut short; silencing is immediate.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   tif   : tone_if.slave (note_code, volume in; sq_out, audio_out, active out)
module tone_generator #(
  parameter int MAX_OCTAVE  = 4,
  parameter int SILENT_NOTE = 14,
  parameter int CNT_W       = 17
) (
  input  logic   clk,
  input  logic   rst_n,
  tone_if.slave  tif
);

  localparam logic [6:0] SILENT_CODE = {3'b000, 4'(SILENT_NOTE)};

  typedef enum logic {S_SILENT, S_PLAYING} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic [6:0]       applied_q, applied_d;
  logic [6:0]       pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [6:0]       next_code;
  logic [3:0]       pwm_cnt_q;
  logic             audio_q;

  function automatic logic is_pitched(input logic [6:0] code);
    return (int'(code[3:0]) != SILENT_NOTE) && (code[3:0] < 4'd12) &&
           (int'(code[6:4]) <= MAX_OCTAVE);
  endfunction

  // Octave-0 half periods, round(8e6/f) for C2..B2.
  function automatic logic [CNT_W-1:0] half_period(input logic [6:0] code);
    logic [CNT_W-1:0] base;
    case (code[3:0])
      4'd0:    base = CNT_W'(122312);
      4'd1:    base = CNT_W'(115447);
      4'd2:    base = CNT_W'(108968);
      4'd3:    base = CNT_W'(102852);
      4'd4:    base = CNT_W'(97079);
      4'd5:    base = CNT_W'(91630);
      4'd6:    base = CNT_W'(86487);
      4'd7:    base = CNT_W'(81633);
      4'd8:    base = CNT_W'(77051);
      4'd9:    base = CNT_W'(72727);
      4'd10:   base = CNT_W'(68645);
      4'd11:   base = CNT_W'(64792);
      default: base = '0;
    endcase
    return base >> code[6:4];
  endfunction

  // Pitch used by a toggle: the pending code if one was latched before this edge.
  assign next_code = pend_vld_q ? pend_q : applied_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sq_d       = sq_q;
    applied_d  = applied_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    case (state_q)
      S_SILENT: begin
        if (is_pitched(tif.note_code)) begin
          state_d    = S_PLAYING;
          applied_d  = tif.note_code;
          cnt_d      = half_period(tif.note_code) - CNT_W'(1);
          pend_vld_d = 1'b0;
        end
      end
      S_PLAYING: begin
        if (!is_pitched(tif.note_code)) begin
          state_d    = S_SILENT;
          sq_d       = 1'b0;
          cnt_d      = '0;
          pend_vld_d = 1'b0;
        end else if (cnt_q == '0) begin
          // A code first seen on this edge waits for the following toggle.
          sq_d       = ~sq_q;
          applied_d  = next_code;
          cnt_d      = half_period(next_code) - CNT_W'(1);
          pend_d     = tif.note_code;
          pend_vld_d = (tif.note_code != next_code);
        end else begin
          // Last different code wins; returning to the applied code clears it.
          cnt_d      = cnt_q - CNT_W'(1);
          pend_d     = tif.note_code;
          pend_vld_d = (tif.note_code != applied_q);
        end
      end
      default: state_d = S_SILENT;
    endcase
  end

  // Tone stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SILENT;
      cnt_q      <= '0;
      sq_q       <= 1'b0;
      applied_q  <= SILENT_CODE;
      pend_q     <= SILENT_CODE;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sq_q       <= sq_d;
      applied_q  <= applied_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  // PWM gate stage: one cycle behind sq_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      audio_q   <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      audio_q   <= sq_q & (pwm_cnt_q < tif.volume);
    end
  end

  assign tif.sq_out    = sq_q;
  assign tif.audio_out = audio_q;
  assign tif.active    = (state_q == S_PLAYING);

endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
Downstream consumer of the song sequencer's 7-bit note code {octave[2:0], note[3:0]}. Converts the code into an audible square wave by dividing the 16 MHz system clock with a per-note half-period lookup and an octave shift. Applies a 4-bit PWM volume gate before driving the speaker/buzzer pin. Note changes are glitch-free: a pitch change never truncates the current half-cycle.

Parameters:
MAX_OCTAVE, 4, highest valid octave index; codes with octave > MAX_OCTAVE are silent.
SILENT_NOTE, 14, note-field value meaning "note off".
CNT_W, 17, half-period counter width; must hold the largest table entry.

Ports:
clk  input  1  system clock, 16 MHz, rising edge.
rst_n  input  1  asynchronous active-low reset.
note_code  input  7  {octave[6:4], note[3:0]} from the sequencer; may change on any cycle.
volume  input  4  PWM level; 0 = mute, 15 = 15/16 duty.
sq_out  output  1  raw square wave, registered.
audio_out  output  1  sq_out gated by PWM, registered.
active  output  1  1 while a pitched note is applied.

Behaviour:
- One clock: clk. Reset is asynchronous and active-low (rst_n). All state is cleared on assertion regardless of clk.
- Reset values: sq_out=0, audio_out=0, active=0, half-period counter=0, pwm_cnt=0, applied code=silent, pending flag=0.
- Pitched code: note field 0..11 and octave <= MAX_OCTAVE. All other codes are silent, including 12, 13, 15, SILENT_NOTE, and octave 5..7.
- Half period HP = BASE[note] >> octave, where BASE = round(8e6/f) for C2..B2:
  122312, 115447, 108968, 102852, 97079, 91630, 86487, 81633, 77051, 72727, 68645, 64792.
  Truncating shift; the result is always >= 4045.
- Counter operation: the counter down-counts. On the edge where it equals 0 and active=1, sq_out toggles and the counter reloads HP_applied-1. Square period = 2*HP cycles.
- State machine:
  - SILENT (active=0): on the first edge where note_code is pitched, apply the code, load HP-1, set active=1. sq_out stays 0. The first toggle to 1 occurs HP edges later.
  - PLAYING, same code: free-run.
  - PLAYING, different pitched code: latch it as pending. At the next toggle edge, toggle sq_out and reload from the pending code's HP. A newer pitched code arriving before the toggle overwrites pending (last wins). A return to the applied code before the toggle clears pending.
  - PLAYING, silent code: on the next edge, sq_out=0, active=0, counter=0, pending cleared. Silencing is immediate, not deferred.
  - Simultaneous events: if a different code is first seen on the same edge as a toggle, that toggle uses the old HP. The new code is applied at the following toggle.
- PWM: pwm_cnt is a 4-bit free-running counter with wrap 15->0. audio_out(next) = sq_out(current) & (pwm_cnt < volume). This gives 1 cycle of latency from sq_out to audio_out. volume=0 forces audio_out=0.
- volume is sampled every cycle, with no synchronisation or deferral.
- Reset mid-note: outputs drop on rst_n assertion. After release the block starts in SILENT and re-acquires note_code on the first edge.
- note_code is treated as synchronous to clk; no input synchroniser.

Test Plan:
1. Reset, note_code=7'h09 (oct0, A), volume=15 -> active=1 one edge after release; sq_out rises 72727 cycles after load; period 145454 cycles.
2. note_code=7'h29 (oct2, A) -> HP=18181, period 36362; octave 7'h49 -> HP=4545.
3. Playing 7'h09, switch to 7'h00 mid half-cycle -> current half-cycle completes at 72727; subsequent half-cycles are 122312. Switching 7'h00->7'h05->7'h09 within one half-cycle -> only 7'h09 is applied.
4. Playing, note_code=7'h0E or 7'h0C or 7'h59 -> next edge: sq_out=0, active=0; code 7'h09 restarts from SILENT timing.
5. volume=4, sq_out high -> audio_out high on exactly 4 of every 16 cycles (pwm_cnt 0..3); volume=0 -> audio_out constantly 0 while sq_out toggles.
6. Assert rst_n low mid-half-cycle, asynchronously -> sq_out, audio_out, active go 0 without a clk edge. Release -> identical timing to scenario 1.
